// File: rtl/sram_pkg.sv
// Types shared by the SRAM request adapter and its response queue.
package sram_pkg;

  typedef enum logic {
    SRAM_RD = 1'b0,
    SRAM_WR = 1'b1
  } sram_type_e;

  localparam int SRAM_DATA_NBITS = 32;

  // Response record at the default data width; the adapter builds the same
  // layout sized to its own data width.
  typedef struct packed {
    sram_type_e                 rtype;
    logic [SRAM_DATA_NBITS-1:0] data;
  } sram_resp_t;

endpackage

// File: rtl/sram_resp_queue.sv
// Small circular response buffer; enqueue is trusted never to hit a full queue.
module sram_resp_queue #(
  parameter int  DEPTH     = 3,
  parameter type T         = logic,
  parameter int  CNT_NBITS = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enq_val,
  input  T                     enq_data,
  output logic                 deq_val,
  input  logic                 deq_rdy,
  output T                     deq_data,
  output logic [CNT_NBITS-1:0] count
);

  localparam int PTR_NBITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                     mem_q [DEPTH];
  logic [PTR_NBITS-1:0] wptr_q, wptr_d;
  logic [PTR_NBITS-1:0] rptr_q, rptr_d;
  logic [CNT_NBITS-1:0] count_q, count_d;
  logic                 do_deq;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_NBITS-1:0] ptr_inc(input logic [PTR_NBITS-1:0] p);
    return (p == PTR_NBITS'(DEPTH - 1)) ? '0 : p + PTR_NBITS'(1);
  endfunction

  always_comb begin
    do_deq  = (count_q != '0) && deq_rdy;
    wptr_d  = enq_val ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = do_deq ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q;
    if (enq_val && !do_deq) begin
      count_d = count_q + CNT_NBITS'(1);
    end else if (!enq_val && do_deq) begin
      count_d = count_q - CNT_NBITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_val) begin
      mem_q[wptr_q] <= enq_data;
    end
  end

  assign deq_val  = (count_q != '0);
  assign deq_data = mem_q[rptr_q];
  assign count    = count_q;

endmodule

// File: rtl/sram_req_adapter.sv
// Turns val/rdy requests into single-port SRAM accesses and returns ordered
// responses through a 3-entry queue sized to cover the SRAM read latency.
module sram_req_adapter
  import sram_pkg::*;
#(
  parameter  int p_data_nbits  = 32,
  parameter  int p_num_entries = 256,
  localparam int c_addr_nbits  = $clog2(p_num_entries),
  localparam int c_qdepth      = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_val,
  output logic                      req_rdy,
  input  logic                      req_type,
  input  logic [31:0]               req_addr,
  input  logic [p_data_nbits/8-1:0] req_wben,
  input  logic [p_data_nbits-1:0]   req_data,
  output logic                      resp_val,
  input  logic                      resp_rdy,
  output logic                      resp_type,
  output logic [p_data_nbits-1:0]   resp_data,
  output logic                      port0_val,
  output logic                      port0_type,
  output logic [c_addr_nbits-1:0]   port0_idx,
  output logic [p_data_nbits/8-1:0] port0_wben,
  output logic [p_data_nbits-1:0]   port0_wdata,
  input  logic [p_data_nbits-1:0]   port0_rdata
);

  localparam int c_cnt_nbits = $clog2(c_qdepth + 1);
  localparam int c_occ_nbits = c_cnt_nbits + 1;

  typedef struct packed {
    sram_type_e              rtype;
    logic [p_data_nbits-1:0] data;
  } resp_t;

  logic                   rdy_en_q, rdy_en_d;
  logic                   inflight_val_q, inflight_val_d;
  sram_type_e             inflight_type_q, inflight_type_d;
  logic [c_cnt_nbits-1:0] q_count;
  logic [c_occ_nbits-1:0] occupancy;
  resp_t                  q_enq_data, q_deq_data;
  logic                   unused_addr_bits;

  // Credit check uses registered state only, so resp_rdy never reaches req_rdy.
  assign occupancy = c_occ_nbits'(inflight_val_q) + c_occ_nbits'(q_count);
  assign req_rdy   = rdy_en_q && (occupancy < c_occ_nbits'(c_qdepth));

  assign port0_val   = req_val && req_rdy;
  assign port0_type  = req_type;
  assign port0_idx   = req_addr[c_addr_nbits+1:2];
  assign port0_wben  = req_wben;
  assign port0_wdata = req_data;

  assign unused_addr_bits = ^{req_addr[31:c_addr_nbits+2], req_addr[1:0]};

  always_comb begin
    rdy_en_d         = 1'b1;
    inflight_val_d   = port0_val;
    inflight_type_d  = sram_type_e'(req_type);
    q_enq_data.rtype = inflight_type_q;
    q_enq_data.data  = (inflight_type_q == SRAM_RD) ? port0_rdata : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_en_q       <= 1'b0;
      inflight_val_q <= 1'b0;
    end else begin
      rdy_en_q       <= rdy_en_d;
      inflight_val_q <= inflight_val_d;
    end
  end

  always_ff @(posedge clk) begin
    if (port0_val) begin
      inflight_type_q <= inflight_type_d;
    end
  end

  sram_resp_queue #(
    .DEPTH     (c_qdepth),
    .T         (resp_t),
    .CNT_NBITS (c_cnt_nbits)
  ) u_resp_queue (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (inflight_val_q),
    .enq_data (q_enq_data),
    .deq_val  (resp_val),
    .deq_rdy  (resp_rdy),
    .deq_data (q_deq_data),
    .count    (q_count)
  );

  assign resp_type = q_deq_data.rtype;
  assign resp_data = q_deq_data.data;

endmodule

// File: tb/tb_sram_req_adapter.sv
// Bench for sram_req_adapter: directed table, multi-cycle corner sequences and
// randomized traffic checked by a memory/ordered-response reference model.
module tb_sram_req_adapter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val, req_rdy, req_type;
  logic [31:0] req_addr;
  logic [3:0]  req_wben;
  logic [31:0] req_data;
  logic        resp_val, resp_rdy, resp_type;
  logic [31:0] resp_data;
  logic        port0_val, port0_type;
  logic [7:0]  port0_idx;
  logic [3:0]  port0_wben;
  logic [31:0] port0_wdata;
  logic [31:0] port0_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit done     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_req_adapter #(.p_data_nbits(32), .p_num_entries(256)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_type(req_type),
    .req_addr(req_addr), .req_wben(req_wben), .req_data(req_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_type(resp_type),
    .resp_data(resp_data),
    .port0_val(port0_val), .port0_type(port0_type), .port0_idx(port0_idx),
    .port0_wben(port0_wben), .port0_wdata(port0_wdata), .port0_rdata(port0_rdata)
  );

  // Synchronous SRAM: read data appears the cycle after the enable.
  logic [31:0] sram [256];
  always @(posedge clk) begin
    if (port0_val) begin
      if (port0_type) begin
        for (int b = 0; b < 4; b++)
          if (port0_wben[b]) sram[port0_idx][8*b +: 8] <= port0_wdata[8*b +: 8];
      end else begin
        port0_rdata <= sram[port0_idx];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: word memory indexed modulo depth, plus ordered expectations.
  typedef struct { logic t; logic [31:0] d; } exp_t;
  exp_t        exp_q [$];
  exp_t        e;
  logic [31:0] ref_mem [256];
  int          ridx;
  bit          prev_stall = 0;
  logic        prev_t;
  logic [31:0] prev_d;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("resp_hold_val", resp_val, 1);
        check("resp_hold_data", {resp_type, resp_data}, {prev_t, prev_d});
      end
      if (resp_val && resp_rdy) begin
        if (exp_q.size() == 0) flag("sb_unexpected_resp");
        else begin
          e = exp_q.pop_front();
          check("sb_resp_type", resp_type, e.t);
          check("sb_resp_data", resp_data, e.d);
        end
      end
      if (req_val && req_rdy) begin
        ridx = int'((req_addr >> 2) % 256);
        if (req_type) begin
          for (int b = 0; b < 4; b++)
            if (req_wben[b]) ref_mem[ridx][8*b +: 8] = req_data[8*b +: 8];
          e.t = 1'b1; e.d = 32'h0;
        end else begin
          e.t = 1'b0; e.d = ref_mem[ridx];
        end
        exp_q.push_back(e);
      end
      prev_stall = resp_val && !resp_rdy;
      prev_t     = resp_type;
      prev_d     = resp_data;
    end
  end

  // One request, then wait for its response; call aligned just after a rising edge.
  task automatic single(input logic t, input logic [31:0] a, input logic [3:0] wb,
                        input logic [31:0] d, output logic rt, output logic [31:0] rd,
                        output int lat);
    int  guard, acyc;
    bit  acc, got;
    req_val = 1; req_type = t; req_addr = a; req_wben = wb; req_data = d;
    acc = 0; guard = 0; acyc = 0; rt = 1'bx; rd = 'x; lat = -1;
    while (!acc && guard < 20) begin
      @(negedge clk); acc = req_rdy; acyc = cyc;
      @(posedge clk); #1; guard++;
    end
    req_val = 0;
    check("single_accepted", acc, 1);
    got = 0; guard = 0;
    while (acc && !got && guard < 20) begin
      @(negedge clk);
      if (resp_val) begin got = 1; rt = resp_type; rd = resp_data; lat = cyc - acyc; end
      @(posedge clk); #1; guard++;
    end
    check("single_resp_seen", got, 1);
  endtask

  typedef struct {
    logic t; logic [31:0] a; logic [3:0] wb; logic [31:0] d; logic [31:0] exp;
  } vec_t;
  vec_t tbl [11];

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "timeout");
    end
  end

  initial begin
    logic        rt;
    logic [31:0] rd;
    int          lat, acc, nr, drops, first, last, guard;
    logic [31:0] bp_a [5];

    for (int i = 0; i < 256; i++) begin sram[i] = '0; ref_mem[i] = '0; end
    port0_rdata = '0;
    reset = 0; req_val = 1; req_type = 0; req_addr = 32'h10; req_wben = 4'hF;
    req_data = '0; resp_rdy = 1;

    // Reset state, with req_val high to show no SRAM access leaks out.
    #12;
    check("rst_req_rdy", req_rdy, 0);
    check("rst_resp_val", resp_val, 0);
    check("rst_port0_val", port0_val, 0);
    @(posedge clk); #1; req_val = 0; reset = 1;
    @(posedge clk); @(negedge clk);
    check("rdy_after_reset", req_rdy, 1);
    @(posedge clk); #1;

    tbl[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h11223344, 32'h0};
    tbl[3]  = '{1'b1, 32'h0000_0020, 4'h5, 32'hAAAAAAAA, 32'h0};
    tbl[4]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h0,        32'h11AA33AA};
    tbl[5]  = '{1'b1, 32'h0000_0400, 4'hF, 32'hCAFEF00D, 32'h0};
    tbl[6]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,        32'hCAFEF00D};
    tbl[7]  = '{1'b1, 32'h0000_03FC, 4'h8, 32'h12345678, 32'h0};
    tbl[8]  = '{1'b0, 32'hFFFF_F7FC, 4'h0, 32'h0,        32'h12000000};
    tbl[9]  = '{1'b0, 32'h0000_0013, 4'h0, 32'h0,        32'hDEADBEEF};
    tbl[10] = '{1'b0, 32'h0000_0008, 4'h0, 32'h0,        32'h0};
    for (int i = 0; i < 11; i++) begin
      single(tbl[i].t, tbl[i].a, tbl[i].wb, tbl[i].d, rt, rd, lat);
      check($sformatf("tbl%0d_type", i), rt, tbl[i].t);
      check($sformatf("tbl%0d_data", i), rd, tbl[i].exp);
      check($sformatf("tbl%0d_latency", i), lat, 2);
    end

    // Backpressure: only three requests fit while responses are stalled.
    bp_a[0] = 32'h10; bp_a[1] = 32'h20; bp_a[2] = 32'h0; bp_a[3] = 32'h3FC; bp_a[4] = 32'h14;
    resp_rdy = 0; req_val = 1; req_type = 0; req_addr = bp_a[0]; acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); if (req_rdy) acc++;
      @(posedge clk); #1; if (acc < 5) req_addr = bp_a[acc];
    end
    @(negedge clk);
    check("bp_accepted", acc, 3);
    check("bp_req_rdy", req_rdy, 0);
    check("bp_no_sram_access", port0_val, 0);
    check("bp_resp_val", resp_val, 1);
    @(posedge clk); #1;
    resp_rdy = 1; nr = 0; guard = 0;
    while ((acc < 5 || nr < 5) && guard < 40) begin
      @(negedge clk);
      if (req_val && req_rdy) acc++;
      if (resp_val && resp_rdy) nr++;
      @(posedge clk); #1; guard++;
      if (acc >= 5) req_val = 0; else req_addr = bp_a[acc];
    end
    check("bp_total_accepted", acc, 5);
    check("bp_responses", nr, 5);

    // Throughput: 16 back-to-back reads with the sink always ready.
    req_val = 1; req_type = 0; req_addr = 32'h0;
    acc = 0; nr = 0; drops = 0; first = -1; last = -1; guard = 0;
    while ((acc < 16 || nr < 16) && guard < 80) begin
      @(negedge clk);
      if (req_val) begin if (req_rdy) acc++; else drops++; end
      if (resp_val) begin if (first < 0) first = cyc; last = cyc; nr++; end
      @(posedge clk); #1; guard++;
      if (acc >= 16) req_val = 0; else req_addr = acc * 4;
    end
    check("tp_accepted", acc, 16);
    check("tp_rdy_drops", drops, 0);
    check("tp_responses", nr, 16);
    check("tp_consecutive", last - first, 15);

    // Reset with two responses queued discards them; memory survives.
    resp_rdy = 0; req_val = 1; req_type = 0; req_addr = 32'h10; acc = 0; guard = 0;
    while (acc < 2 && guard < 10) begin
      @(negedge clk); if (req_rdy) acc++;
      @(posedge clk); #1; guard++; req_addr = 32'h20;
    end
    req_val = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_rst_pre_resp_val", resp_val, 1);
    @(posedge clk); #2;
    reset = 0; #1;
    check("mid_rst_resp_val", resp_val, 0);
    check("mid_rst_req_rdy", req_rdy, 0);
    repeat (2) @(posedge clk);
    #1; reset = 1;
    @(posedge clk); #1; resp_rdy = 1;
    single(1'b0, 32'h10, 4'h0, 32'h0, rt, rd, lat);
    check("post_rst_type", rt, 0);
    check("post_rst_data", rd, 32'hDEADBEEF);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      req_val  = ($urandom % 3) != 0;
      req_type = $urandom % 2;
      req_addr = $urandom;
      req_wben = $urandom % 16;
      req_data = $urandom;
      resp_rdy = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    req_val = 0; resp_rdy = 1;
    repeat (10) @(posedge clk);
    #1;
    check("drain_model_empty", exp_q.size(), 0);
    check("drain_resp_val", resp_val, 0);

    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_req_adapter.md
SRAM_REQ_ADAPTER -- requirements
Module: sram_req_adapter

Interface
REQ-001 Parameters SHALL be: p_data_nbits, default 32, data width; p_num_entries, default 256, SRAM depth; c_addr_nbits = $clog2(p_num_entries); c_qdepth = 3, response-queue depth.
REQ-002 Ports SHALL be, in order:
  clk  in  1  sole clock, rising edge;
  reset  in  1  asynchronous, active-low reset;
  req_val  in  1  request valid;
  req_rdy  out  1  request ready;
  req_type  in  1  0 = read, 1 = write;
  req_addr  in  32  byte address;
  req_wben  in  p_data_nbits/8  write byte enables;
  req_data  in  p_data_nbits  write data;
  resp_val  out  1  response valid;
  resp_rdy  in  1  response ready;
  resp_type  out  1  echo of the request type;
  resp_data  out  p_data_nbits  read data, zero for writes;
  port0_val  out  1  SRAM enable;
  port0_type  out  1  SRAM transaction type;
  port0_idx  out  c_addr_nbits  SRAM index;
  port0_wben  out  p_data_nbits/8  SRAM byte enables;
  port0_wdata  out  p_data_nbits  SRAM write data;
  port0_rdata  in  p_data_nbits  SRAM read data, valid one cycle after enable.

Function
REQ-003 A request transfer SHALL occur on any rising edge with req_val && req_rdy both high; a response transfer SHALL occur on any rising edge with resp_val && resp_rdy both high.
REQ-004 port0_val SHALL equal req_val && req_rdy (combinational); port0_type, port0_wben and port0_wdata SHALL pass req_type, req_wben and req_data through.
REQ-005 port0_idx SHALL equal req_addr[c_addr_nbits+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo p_num_entries.
REQ-006 An in-flight register SHALL record each accepted request's type in cycle N.
REQ-007 At the end of cycle N+1, the in-flight entry SHALL be enqueued: {type, port0_rdata} for a read, {type, 0} for a write.
REQ-008 Minimum latency SHALL be 2 cycles: a request accepted in cycle N gives resp_val = 1 in cycle N+2.
REQ-009 req_rdy SHALL be high iff (inflight + queue count) < c_qdepth, registered state only; there SHALL be no combinational path from resp_rdy to req_rdy.
REQ-010 With resp_rdy held high, the block SHALL sustain one request and one response per cycle.
REQ-011 Responses SHALL be returned strictly in request order.
REQ-012 When the queue is full and the in-flight register is occupied, req_rdy SHALL be 0 and no SRAM access SHALL issue.
REQ-013 Simultaneous enqueue and dequeue on a non-empty queue SHALL leave the count unchanged.
REQ-014 Enqueue into an empty queue SHALL NOT bypass it: the response becomes visible the following cycle.
REQ-015 resp_val, resp_type and resp_data SHALL be stable while resp_val && !resp_rdy.
REQ-016 The queue read and write pointers SHALL wrap from c_qdepth-1 to 0.

Reset
REQ-017 While reset = 0: in-flight valid, queue count and pointers SHALL clear asynchronously; req_rdy = 0, resp_val = 0, port0_val = 0.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight and queued responses; SRAM contents are not cleared.
REQ-019 req_rdy SHALL rise in the first cycle after reset deasserts.

Structure
REQ-020 A shared package sram_pkg SHALL hold the read/write type enum (SRAM_RD = 0, SRAM_WR = 1) and the response struct {type, data}.
REQ-021 The response buffer SHALL be a sub-module sram_resp_queue, parameterised by depth and by the struct type, instantiated once.
REQ-022 The adapter SHALL instantiate no SRAM; the bench connects it to a synchronous SRAM model.

Verification
REQ-023 Write then read: write addr 0x0000_0010, data 0xDEADBEEF, wben 4'hF; then read 0x10 -> write response type 1 data 0, then read response 0xDEADBEEF, read response arriving 2 cycles after acceptance.
REQ-024 Byte enables: write 0x11223344, then write 0xAAAAAAAA with wben 4'b0101, then read -> 0x11AA33AA.
REQ-025 Backpressure: resp_rdy = 0, issue 5 reads -> exactly 3 accepted, req_rdy = 0; raise resp_rdy -> 5 responses in order with correct data.
REQ-026 Throughput: 16 back-to-back reads with resp_rdy = 1 -> req_rdy never drops, 16 responses on consecutive cycles.
REQ-027 Wrap: write to addr 0x400 (idx 0 when p_num_entries = 256), read addr 0x0 -> same data.
REQ-028 Reset mid-stream: assert reset with 2 responses queued -> resp_val = 0 immediately; after release, a read of previously written data returns the correct value.
